// File: rtl/ram_loader.sv
// Streams a byte block into RAM at consecutive addresses, then reads it back and compares checksums.
// One byte per cycle in both phases, so a gap-free load of N bytes runs start -> done in 2N+2 cycles. in_ready is high for the whole LOAD phase.
module ram_loader #(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ADDR,
  output logic              WE,
  output logic              CS,
  output logic [7:0]        DI,
  input  logic [7:0]        DO,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, FINISH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [7:0]        checksum_q, checksum_d;
  logic [7:0]        vsum_q, vsum_d;
  logic              error_q, error_d;
  logic              done_q, done_d;
  logic              last_byte;

  assign last_byte = (count_q == len_q - LEN_W'(1));

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    count_d    = count_q;
    checksum_d = checksum_q;
    vsum_d     = vsum_q;
    error_d    = error_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d     = base_addr;
          len_d      = length;
          count_d    = '0;
          checksum_d = '0;
          vsum_d     = '0;
          error_d    = 1'b0;
          state_d    = (length == '0) ? FINISH : LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          checksum_d = checksum_q + in_data;
          count_d    = count_q + LEN_W'(1);
          if (last_byte) begin
            count_d = '0;
            vsum_d  = '0;
            state_d = VERIFY;
          end
        end
      end
      VERIFY: begin
        vsum_d  = vsum_q + DO;
        count_d = count_q + LEN_W'(1);
        if (last_byte) state_d = FINISH;
      end
      FINISH: begin
        done_d  = 1'b1;
        error_d = (vsum_q != checksum_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      count_q    <= '0;
      checksum_q <= '0;
      vsum_q     <= '0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      count_q    <= count_d;
      checksum_q <= checksum_d;
      vsum_q     <= vsum_d;
      error_q    <= error_d;
      done_q     <= done_d;
    end
  end

  // Strobes come straight from state so start can never glitch the RAM port.
  assign in_ready = (state_q == LOAD);
  assign CS       = (state_q == LOAD) || (state_q == VERIFY);
  assign WE       = (state_q == LOAD) && in_valid;
  assign DI       = in_data;
  assign ADDR     = base_q + ADDR_W'(count_q);
  assign cpu_hold = (state_q != IDLE);
  assign busy     = CS;
  assign done     = done_q;
  assign error    = error_q;
  assign checksum = checksum_q;

endmodule
